// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch types, jump opcode and jump target helper
package cpu_pkg;

    localparam logic [5:0] OPC_J = 6'b000010;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_e;

    // Region bits come from the address after the jump, as in MIPS J-type.
    function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [31:0] inst);
        logic [31:0] pc_plus4;
        pc_plus4 = pc + 32'd4;
        return {pc_plus4[31:28], inst[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry FIFO of {pc, inst} pairs with flush
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic [CW-1:0] count
);

    fetch_entry_t  store_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;
    logic          do_push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && !flush;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                store_q[wr_ptr_q] <= push_data;
            end
        end
    end

    // The credit rule upstream keeps a push from ever landing on a full queue.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(do_push && !do_pop && (count_q == CW'(DEPTH))));

    assign head  = store_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, imem requester, jump predecode and decode-side queue
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = CW + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   tag_pc_q, tag_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          inflight_q, inflight_d;
    logic          tag_epoch_q, tag_epoch_d;
    logic          epoch_q, epoch_d;

    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  resp;
    logic [OW-1:0] occupancy;
    logic          pop;
    logic          issue;
    logic          push;
    logic          local_jump;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_BOOT) begin
            state_d = ST_RUN;
        end
    end

    // Credits: queued entries plus the outstanding fetch must leave room after this pop.
    always_comb begin
        pop       = out_valid && out_ready;
        occupancy = OW'(count) + OW'(inflight_q) - OW'(pop);
        issue     = (state_q == ST_RUN) && !redirect_valid && (occupancy < OW'(DEPTH));
    end

    // A stale epoch marks a response whose fetch was overtaken by a redirect.
    always_comb begin
        push       = inflight_q && (tag_epoch_q == epoch_q) && !redirect_valid;
        local_jump = push && (imem_inst[31:26] == OPC_J);
        resp       = '{pc: tag_pc_q, inst: imem_inst};
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~32'd3;
        end else if (local_jump) begin
            pc_d = jump_target(tag_pc_q, imem_inst);
        end else if (issue) begin
            pc_d = pc_q + 32'd4;
        end
        inflight_d  = issue;
        tag_pc_d    = issue ? pc_q : tag_pc_q;
        tag_epoch_d = issue ? epoch_q : tag_epoch_q;
        epoch_d     = epoch_q ^ (redirect_valid | local_jump);
        addr_d      = issue ? {2'b00, pc_q[31:2]} : addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            tag_pc_q    <= '0;
            addr_q      <= {2'b00, RESET_PC[31:2]};
            inflight_q  <= 1'b0;
            tag_epoch_q <= 1'b0;
            epoch_q     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            tag_pc_q    <= tag_pc_d;
            addr_q      <= addr_d;
            inflight_q  <= inflight_d;
            tag_epoch_q <= tag_epoch_d;
            epoch_q     <= epoch_d;
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (resp),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

    assign imem_pc   = addr_d;
    assign out_valid = (count != '0);
    assign out_pc    = head.pc;
    assign out_inst  = head.inst;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized fetch_unit bench against a queue-level model
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_inst;

    logic [31:0] mem [256];

    int n_checks = 0;
    int n_fail = 0;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic [31:0] m_pend_pc;
    bit          m_boot;
    bit          m_pend_valid;
    bit          m_pend_live;

    always #5 clk = ~clk;

    always @(posedge clk) imem_inst <= mem[imem_pc[7:0]];

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    function automatic logic [31:0] memw(input logic [31:0] pc);
        return mem[pc[9:2]];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc         = RESET_PC;
        m_addr       = {2'b00, RESET_PC[31:2]};
        m_pend_valid = 0;
        m_pend_live  = 0;
        m_pend_pc    = 32'h0;
        m_boot       = 1;
    endtask

    // Apply inputs for this cycle, compare DUT to model, then advance the model.
    task automatic body(input bit rdy, input bit rv, input logic [31:0] rpc);
        bit          pop, issue, resp_push, jump;
        int          occ;
        logic [31:0] exp_addr, rinst, next_pc, t;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        pop      = (m_q.size() != 0) && rdy;
        occ      = m_q.size() + (m_pend_valid ? 1 : 0) - (pop ? 1 : 0);
        issue    = !m_boot && !rv && (occ < 2);
        exp_addr = issue ? {2'b00, m_pc[31:2]} : m_addr;
        chk("out_valid", out_valid, (m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("out_pc", out_pc, m_q[0].pc);
            chk("out_inst", out_inst, m_q[0].inst);
        end
        chk("imem_pc", imem_pc, exp_addr);

        if (pop) void'(m_q.pop_front());
        rinst     = memw(m_pend_pc);
        resp_push = m_pend_valid && m_pend_live && !rv;
        jump      = resp_push && (rinst[31:26] == 6'b000010);
        next_pc   = m_pc;
        if (rv) begin
            m_q.delete();
            next_pc = rpc & ~32'd3;
        end else begin
            if (resp_push) m_q.push_back('{pc: m_pend_pc, inst: rinst});
            if (jump) begin
                t       = m_pend_pc + 32'd4;
                next_pc = {t[31:28], rinst[25:0], 2'b00};
            end else if (issue) begin
                next_pc = m_pc + 32'd4;
            end
        end
        m_pend_valid = issue;
        m_pend_live  = issue && !jump;
        m_pend_pc    = m_pc;
        m_addr       = exp_addr;
        m_pc         = next_pc;
        m_boot       = 0;
    endtask

    task automatic cyc(input bit rdy, input bit rv, input logic [31:0] rpc);
        @(negedge clk);
        body(rdy, rv, rpc);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        body(1'b1, 1'b0, 32'h0);
    endtask

    task automatic next_del(input string name, input logic [31:0] epc, input logic [31:0] einst);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            if (out_valid === 1'b1) seen = 1;
        end
        chk({name, "_seen"}, seen, 1);
        if (seen) begin
            chk({name, "_pc"}, out_pc, epc);
            chk({name, "_inst"}, out_inst, einst);
        end
    endtask

    task automatic chk_reset_outputs(input string name);
        #1;
        chk({name, "_valid"}, out_valid, 0);
        chk({name, "_pc"}, out_pc, 0);
        chk({name, "_inst"}, out_inst, 0);
        chk({name, "_imem"}, imem_pc, {2'b00, RESET_PC[31:2]});
    endtask

    initial begin
        bit          found;
        logic [31:0] w;

        for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000 + i;
        mem[0] = 32'h0001_1022;
        mem[1] = 32'h0022_1824;
        mem[2] = 32'h0041_3025;
        mem[6] = 32'h0800_0004;
        for (int i = 20; i < 254; i++) begin
            if ($urandom_range(0, 11) == 0)
                mem[i] = {6'b000010, 18'h0, 8'($urandom_range(0, 255))};
            else
                mem[i] = {6'b100011, 26'($urandom)};
        end

        // Reset state and streaming latency.
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        release_reset();
        cyc(1'b1, 1'b0, 32'h0);
        chk("lat_c1_valid", out_valid, 0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("lat_c2_valid", out_valid, 0);
        cyc(1'b1, 1'b0, 32'h0);
        chk("first_valid", out_valid, 1);
        chk("first_pc", out_pc, 32'h0);
        chk("first_inst", out_inst, 32'h0001_1022);
        cyc(1'b1, 1'b0, 32'h0);
        chk("second_pc", out_pc, 32'h4);
        chk("second_inst", out_inst, 32'h0022_1824);
        cyc(1'b1, 1'b0, 32'h0);
        chk("third_pc", out_pc, 32'h8);
        chk("third_inst", out_inst, 32'h0041_3025);

        // Local jump at 0x18 loops back to 0x10.
        next_del("s_0c", 32'h0C, 32'h2000_0003);
        next_del("s_10", 32'h10, 32'h2000_0004);
        next_del("s_14", 32'h14, 32'h2000_0005);
        next_del("jump_word", 32'h18, 32'h0800_0004);
        next_del("after_jump", 32'h10, 32'h2000_0004);

        // Backpressure until full, then external redirect to 0x43.
        repeat (6) cyc(1'b0, 1'b0, 32'h0);
        chk("bp_full_valid", out_valid, 1);
        cyc(1'b0, 1'b1, 32'h0000_0043);
        cyc(1'b1, 1'b0, 32'h0);
        chk("flush_valid", out_valid, 0);
        next_del("redir", 32'h40, 32'h2000_0010);
        repeat (4) cyc(1'b0, 1'b0, 32'h0);
        next_del("bp_cont1", 32'h44, 32'h2000_0011);
        next_del("bp_cont2", 32'h48, 32'h2000_0012);

        // Collision: redirect in the very cycle the jump word at 0x18 returns.
        cyc(1'b1, 1'b1, 32'h0);
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            w = memw(m_pend_pc);
            if (m_pend_valid && m_pend_live && w[31:26] == 6'b000010) found = 1;
            else cyc(1'b1, 1'b0, 32'h0);
        end
        chk("coll_found", found, 1);
        chk("coll_jump_pc", m_pend_pc, 32'h18);
        cyc(1'b1, 1'b1, 32'h20);
        next_del("coll", 32'h20, 32'h2000_0008);

        // PC wrap at the top of the address space.
        cyc(1'b1, 1'b1, 32'hFFFF_FFF8);
        next_del("wrap_f8", 32'hFFFF_FFF8, 32'h2000_00FE);
        next_del("wrap_fc", 32'hFFFF_FFFC, 32'h2000_00FF);
        next_del("wrap_0", 32'h0, 32'h0001_1022);

        // Randomized traffic.
        repeat (3000) begin
            cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0), 32'($urandom_range(0, 1023)));
        end

        // Reset mid-operation with the queue full.
        repeat (4) cyc(1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        chk_reset_outputs("midreset");
        release_reset();
        next_del("post_reset", RESET_PC, 32'h0001_1022);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
